// File: rtl/issue_scheduler_pkg.sv
// Shared configuration and entry types for the out-of-order issue scheduler.
// Also holds the per-register and ordering-hazard helper functions.
package issue_scheduler_pkg;

  localparam int INSTRUCTION_QUEUE_DEPTH = 4;
  localparam int CFG_NUM_UNITS           = 4;
  localparam int CFG_STARVE_LIMIT        = 8;
  localparam int REG_AW                  = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t rs1;
    reg_addr_t rs2;
    reg_addr_t rd;
    logic      use_rs1;
    logic      use_rs2;
    logic      use_rd;
  } issue_entry_t;

  function automatic logic reg_pass(logic use_f, reg_addr_t a, logic [31:0] sb);
    return !use_f || (a == '0) || !sb[a];
  endfunction

  // Ordering hazard of a younger entry against one older unissued entry.
  // A write to x0 is discarded, so it never creates a WAR or WAW hazard.
  function automatic logic order_hazard(issue_entry_t yng, issue_entry_t old);
    logic raw, war, waw;
    raw = old.use_rd && (old.rd != '0) &&
          ((yng.use_rs1 && yng.rs1 == old.rd) || (yng.use_rs2 && yng.rs2 == old.rd));
    war = yng.use_rd && (yng.rd != '0) &&
          ((old.use_rs1 && old.rs1 == yng.rd) || (old.use_rs2 && old.rs2 == yng.rd));
    waw = yng.use_rd && old.use_rd && (yng.rd != '0) && (yng.rd == old.rd);
    return raw || war || waw;
  endfunction

endpackage

// File: rtl/issue_scheduler_scoreboard.sv
// Register scoreboard: one busy bit per architectural register, set on issue of a
// writer and cleared on writeback, with per-entry rs1/rs2 read checks and an rd write check.
module register_scoreboard
  import issue_scheduler_pkg::*;
#(
  parameter int DEPTH = INSTRUCTION_QUEUE_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     set_en,
  input  reg_addr_t                set_rd,
  input  logic                     clr_en,
  input  reg_addr_t                clr_rd,
  input  issue_entry_t [DEPTH-1:0] ent,
  output logic [DEPTH-1:0]         ent_ready
);

  logic [31:0] sb_q, sb_d;

  // Set is applied after clear so a same-register collision leaves the bit busy.
  always_comb begin
    sb_d = sb_q;
    if (clr_en) sb_d[clr_rd] = 1'b0;
    if (set_en) sb_d[set_rd] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sb_q <= '0;
    else      sb_q <= sb_d;
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_chk
    assign ent_ready[e] = reg_pass(ent[e].use_rs1, ent[e].rs1, sb_q) &
                          reg_pass(ent[e].use_rs2, ent[e].rs2, sb_q) &
                          reg_pass(ent[e].use_rd,  ent[e].rd,  sb_q);
  end

endmodule

// File: rtl/issue_scheduler.sv
// Out-of-order issue select over the shifting instruction queue: picks the oldest
// eligible entry, drives a one-hot pop, and forces in-order issue when the head starves.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int DEPTH        = INSTRUCTION_QUEUE_DEPTH,
  parameter int NUM_UNITS    = CFG_NUM_UNITS,
  parameter int STARVE_LIMIT = CFG_STARVE_LIMIT,
  parameter int IN_ORDER     = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DEPTH-1:0]             q_valid,
  input  logic [DEPTH*NUM_UNITS-1:0]   q_unit,
  input  logic [DEPTH*REG_AW-1:0]      q_rs1,
  input  logic [DEPTH*REG_AW-1:0]      q_rs2,
  input  logic [DEPTH*REG_AW-1:0]      q_rd,
  input  logic [DEPTH-1:0]             q_use_rs1,
  input  logic [DEPTH-1:0]             q_use_rs2,
  input  logic [DEPTH-1:0]             q_use_rd,
  input  logic [NUM_UNITS-1:0]         unit_ready,
  input  logic                         wb_valid,
  input  logic [REG_AW-1:0]            wb_rd,
  input  logic                         flush,
  output logic [DEPTH-1:0]             q_pop,
  output logic                         issue_valid,
  output logic [$clog2(DEPTH)-1:0]     issue_idx,
  output logic [NUM_UNITS-1:0]         issue_unit,
  output logic                         starving
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  issue_entry_t [DEPTH-1:0]                ent;
  logic         [DEPTH-1:0][NUM_UNITS-1:0] unit_v;
  logic         [DEPTH-1:0]                reg_rdy, haz, elig;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign ent[g].rs1     = q_rs1[g*REG_AW +: REG_AW];
    assign ent[g].rs2     = q_rs2[g*REG_AW +: REG_AW];
    assign ent[g].rd      = q_rd[g*REG_AW +: REG_AW];
    assign ent[g].use_rs1 = q_use_rs1[g];
    assign ent[g].use_rs2 = q_use_rs2[g];
    assign ent[g].use_rd  = q_use_rd[g];
    assign unit_v[g]      = q_unit[g*NUM_UNITS +: NUM_UNITS];
    assign elig[g]        = q_valid[g] & reg_rdy[g] & ~haz[g] &
                            (|(unit_ready & unit_v[g])) & ~flush;
  end

  always_comb begin
    haz = '0;
    for (int i = 0; i < DEPTH; i++)
      for (int j = 0; j < DEPTH; j++)
        if (j > i && q_valid[j] && order_hazard(ent[i], ent[j])) haz[i] = 1'b1;
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             starving_q, starving_d;
  logic             any_v, any_e;
  logic [IDX_W-1:0] old_idx, sel_idx;

  // Ascending scan: the last hit is the highest index, i.e. the oldest.
  always_comb begin
    any_v   = 1'b0;
    any_e   = 1'b0;
    old_idx = '0;
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (q_valid[i]) begin any_v = 1'b1; old_idx = IDX_W'(i); end
      if (elig[i])    begin any_e = 1'b1; sel_idx = IDX_W'(i); end
    end
  end

  always_comb begin
    issue_valid = any_e;
    issue_idx   = sel_idx;
    if (starving_q || (IN_ORDER != 0)) begin
      issue_valid = any_v && elig[old_idx];
      issue_idx   = old_idx;
    end
    q_pop      = issue_valid ? (DEPTH'(1) << issue_idx) : '0;
    issue_unit = issue_valid ? unit_v[issue_idx] : '0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (flush || (q_valid == '0))
      cnt_d = '0;
    else if (issue_valid)
      cnt_d = (issue_idx == old_idx) ? '0 :
              (cnt_q == CNT_W'(STARVE_LIMIT)) ? cnt_q : cnt_q + CNT_W'(1);
    starving_d = (cnt_d == CNT_W'(STARVE_LIMIT));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q      <= '0;
      starving_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      starving_q <= starving_d;
    end
  end

  assign starving = starving_q;

  register_scoreboard #(.DEPTH(DEPTH)) u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_en    (issue_valid && ent[issue_idx].use_rd && (ent[issue_idx].rd != '0)),
    .set_rd    (ent[issue_idx].rd),
    .clr_en    (wb_valid),
    .clr_rd    (wb_rd),
    .ent       (ent),
    .ent_ready (reg_rdy)
  );

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: hand-computed pop/index/starvation/scoreboard
// expectations for dependent and independent queue contents.
module tb_issue_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  q_valid;
  logic [15:0] q_unit;
  logic [19:0] q_rs1, q_rs2, q_rd;
  logic [3:0]  q_use_rs1, q_use_rs2, q_use_rd;
  logic [3:0]  unit_ready;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [3:0]  q_pop;
  logic        issue_valid;
  logic [1:0]  issue_idx;
  logic [3:0]  issue_unit;
  logic        starving;

  int n_chk = 0;
  int n_err = 0;

  localparam logic [3:0] ALU = 4'b0001;
  localparam logic [3:0] MUL = 4'b0010;

  issue_scheduler dut (
    .clk(clk), .rst(rst), .q_valid(q_valid), .q_unit(q_unit),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd),
    .q_use_rs1(q_use_rs1), .q_use_rs2(q_use_rs2), .q_use_rd(q_use_rd),
    .unit_ready(unit_ready), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .q_pop(q_pop), .issue_valid(issue_valid), .issue_idx(issue_idx),
    .issue_unit(issue_unit), .starving(starving)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr_q();
    q_valid = '0; q_unit = '0; q_rs1 = '0; q_rs2 = '0; q_rd = '0;
    q_use_rs1 = '0; q_use_rs2 = '0; q_use_rd = '0;
  endtask

  task automatic set_ent(input int i, input logic [3:0] u,
                         input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                         input logic u1, input logic u2, input logic ud);
    q_valid[i]       = 1'b1;
    q_unit[i*4 +: 4] = u;
    q_rs1[i*5 +: 5]  = r1;
    q_rs2[i*5 +: 5]  = r2;
    q_rd[i*5 +: 5]   = rd;
    q_use_rs1[i]     = u1;
    q_use_rs2[i]     = u2;
    q_use_rd[i]      = ud;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; clr_q(); unit_ready = 4'b1111; wb_valid = 1'b0; wb_rd = '0; flush = 1'b0;
    #1;
    chk("reset_pop", q_pop, 0);
    chk("reset_valid", issue_valid, 0);
    chk("reset_starving", starving, 0);
    chk("reset_sb", dut.u_sb.sb_q, 0);
    #2 rst = 1'b1;
    step();

    // Oldest ALU writer issues in order and marks x5 busy.
    set_ent(3, ALU, 0, 0, 5, 0, 0, 1);
    #1;
    chk("t1_pop", q_pop, 4'b1000);
    chk("t1_idx", issue_idx, 3);
    chk("t1_unit", issue_unit, ALU);
    step();
    chk("t1_sb", dut.u_sb.sb_q, 32'h20);
    chk("t1_cnt", dut.cnt_q, 0);
    clr_q(); set_ent(3, ALU, 5, 0, 0, 1, 0, 0);
    #1 chk("t1_busy_block", q_pop, 0);
    clr_q(); wb_valid = 1'b1; wb_rd = 5;
    #1 chk("empty_pop", q_pop, 0);
    step();
    wb_valid = 1'b0;
    chk("t1_sb_clr", dut.u_sb.sb_q, 0);

    // Head waits on busy MUL; independent younger ALU bypasses it.
    set_ent(3, MUL, 0, 0, 8, 0, 0, 1);
    set_ent(2, ALU, 6, 0, 0, 1, 0, 0);
    unit_ready = 4'b1101;
    #1;
    chk("t2_pop", q_pop, 4'b0100);
    chk("t2_idx", issue_idx, 2);
    step();
    chk("t2_cnt", dut.cnt_q, 1);
    chk("t2_starving", starving, 0);

    // RAW, WAR and WAW against the stalled head all block the younger entry.
    clr_q(); set_ent(3, MUL, 0, 0, 7, 0, 0, 1); set_ent(2, ALU, 7, 0, 0, 1, 0, 0);
    #1 chk("raw_pop", q_pop, 0);
    step();
    chk("raw_cnt_hold", dut.cnt_q, 1);
    clr_q(); set_ent(3, MUL, 11, 0, 0, 1, 0, 0); set_ent(2, ALU, 0, 0, 11, 0, 0, 1);
    #1 chk("war_pop", q_pop, 0);
    clr_q(); set_ent(3, MUL, 0, 0, 12, 0, 0, 1); set_ent(2, ALU, 0, 0, 12, 0, 0, 1);
    #1 chk("waw_pop", q_pop, 0);
    clr_q(); set_ent(2, ALU, 0, 0, 0, 0, 0, 0); flush = 1'b1;
    #1 chk("flush_pop", q_pop, 0);
    step();
    flush = 1'b0;
    chk("flush_cnt", dut.cnt_q, 0);

    // Writeback in the same cycle does not bypass the busy bit.
    clr_q(); unit_ready = 4'b1111; set_ent(3, ALU, 0, 0, 9, 0, 0, 1);
    step();
    clr_q(); set_ent(3, ALU, 9, 0, 0, 1, 0, 0); wb_valid = 1'b1; wb_rd = 9;
    #1 chk("wb_same_cycle_pop", q_pop, 0);
    step();
    wb_valid = 1'b0;
    #1 chk("wb_next_cycle_pop", q_pop, 4'b1000);
    step();

    // Starvation: eight bypasses restrict issue to the head.
    clr_q(); unit_ready = 4'b1101;
    set_ent(3, MUL, 0, 0, 0, 0, 0, 0); set_ent(2, ALU, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) begin
      #1 chk("starve_bypass_pop", q_pop, 4'b0100);
      step();
    end
    chk("starve_cnt7", starving, 0);
    step();
    chk("starve_set", starving, 1);
    chk("starve_suppress_pop", q_pop, 0);
    step();
    chk("starve_hold", starving, 1);
    unit_ready = 4'b1111;
    #1 chk("starve_head_pop", q_pop, 4'b1000);
    step();
    chk("starve_release", starving, 0);

    // Asynchronous reset mid-stream drops busy bits and starvation without an edge.
    clr_q(); set_ent(3, ALU, 0, 0, 5, 0, 0, 1);
    step();
    clr_q(); set_ent(3, ALU, 0, 0, 10, 0, 0, 1);
    step();
    chk("pre_reset_sb", dut.u_sb.sb_q, 32'h420);
    clr_q(); unit_ready = 4'b1101;
    set_ent(3, MUL, 0, 0, 0, 0, 0, 0); set_ent(2, ALU, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 8; k++) step();
    chk("pre_reset_starving", starving, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_sb", dut.u_sb.sb_q, 0);
    chk("async_reset_starving", starving, 0);
    #3 rst = 1'b1;
    clr_q();
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
